// File: rtl/config_memory_unit.sv
// Configuration store: shadows each written word and commits it to the active
// configuration after a settling delay; also owns the system key.
module config_memory_unit #(
  parameter int unsigned APPLY_DELAY = 4,
  parameter logic [34:0] CFG_INIT    = 35'h0,
  parameter logic [1:0]  KEY_INIT    = 2'b10
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        write_en,
  input  logic [34:0] configin,
  input  logic        key_load,
  input  logic [1:0]  new_key,
  output logic [1:0]  syskey,
  output logic [34:0] configout,
  output logic        busy,
  output logic        applied,
  output logic [7:0]  wr_count,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CFG_W = 35;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(APPLY_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CFG_W-1:0] shadow;
  logic [CNT_W-1:0] timer;
  logic             commit_c;
  logic             key_ok_c;

  // A write always wins over an expiring timer.
  assign commit_c = (state_q == HOLD) && !write_en && (timer == '0);
  assign key_ok_c = (state_q == IDLE) && !write_en && key_load;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (write_en) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        HOLD:    state_d = (timer == '0) ? DONE : HOLD;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow, settling timer and write counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shadow   <= '0;
      timer    <= '0;
      wr_count <= '0;
    end else if (write_en) begin
      shadow <= configin;
      timer  <= TIMER_LOAD;
      if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_W'(1);
    end else if (state_q == HOLD && timer != '0) begin
      timer <= timer - CNT_W'(1);
    end
  end

  // Active configuration and system key.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      configout <= CFG_INIT;
      syskey    <= KEY_INIT;
    end else begin
      if (commit_c) configout <= shadow;
      if (key_ok_c) syskey <= new_key;
    end
  end

  assign busy      = (state_q == HOLD);
  assign applied   = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_config_memory_unit.sv
// Bench for config_memory_unit: directed scenarios plus randomized traffic,
// compared cycle by cycle against a pending-word/age reference model.
module tb_config_memory_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        write_en;
  logic [34:0] configin;
  logic        key_load;
  logic [1:0]  new_key;
  logic [1:0]  syskey;
  logic [34:0] configout;
  logic        busy;
  logic        applied;
  logic [7:0]  wr_count;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a pending word ages one per edge and lands when age hits D.
  logic [34:0] m_cfg;
  logic [1:0]  m_key;
  int          m_cnt;
  bit          m_pend;
  logic [34:0] m_data;
  int          m_age;
  bit          m_applied;

  config_memory_unit #(.APPLY_DELAY(D)) dut (
    .clk(clk), .arst(arst), .write_en(write_en), .configin(configin),
    .key_load(key_load), .new_key(new_key), .syskey(syskey),
    .configout(configout), .busy(busy), .applied(applied),
    .wr_count(wr_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cfg = '0; m_key = 2'b10; m_cnt = 0;
    m_pend = 0; m_data = '0; m_age = 0; m_applied = 0;
  endtask

  task automatic model_edge();
    bit idle;
    bit now_applied;
    if (arst) begin
      model_reset();
      return;
    end
    idle = !m_pend && !m_applied;
    now_applied = 0;
    if (write_en) begin
      m_pend = 1; m_data = configin; m_age = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_pend) begin
      m_age++;
      if (m_age == D) begin
        m_cfg = m_data; m_pend = 0; now_applied = 1;
      end
    end else if (idle && key_load) begin
      m_key = new_key;
    end
    m_applied = now_applied;
  endtask

  task automatic check_all();
    logic [1:0] exp_state;
    exp_state = m_pend ? 2'b10 : (m_applied ? 2'b11 : 2'b01);
    check("configout", configout, m_cfg);
    check("syskey", 35'(syskey), 35'(m_key));
    check("busy", 35'(busy), 35'(m_pend));
    check("applied", 35'(applied), 35'(m_applied));
    check("wr_count", 35'(wr_count), 35'(m_cnt));
    check("dbg_state", 35'(dbg_state), 35'(exp_state));
  endtask

  task automatic step(input logic we, input logic [34:0] d, input logic kl,
                      input logic [1:0] nk, input logic rst);
    @(negedge clk);
    write_en = we; configin = d; key_load = kl; new_key = nk; arst = rst;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 35'h0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    arst = 1'b1; write_en = 1'b0; configin = '0; key_load = 1'b0; new_key = '0;
    model_reset();
    step(1'b0, 35'h0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 35'h0, 1'b0, 2'b00, 1'b1);
    idle_steps(3);

    // Single write commits after D edges.
    step(1'b1, 35'h4_0000_00AB, 1'b0, 2'b00, 1'b0);
    idle_steps(D + 3);
    check("commit_ab", configout, 35'h4_0000_00AB);

    // Rewrite restarts the delay; first word never lands.
    step(1'b1, 35'h1, 1'b0, 2'b00, 1'b0);
    idle_steps(1);
    step(1'b1, 35'h2, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < D + 2; i++) begin
      step(1'b0, 35'h0, 1'b0, 2'b00, 1'b0);
      check("never_1", 35'(configout == 35'h1), 35'h0);
    end

    // Write on the last hold edge wins over the commit.
    step(1'b1, 35'h5, 1'b0, 2'b00, 1'b0);
    idle_steps(D - 1);
    step(1'b1, 35'h7, 1'b0, 2'b00, 1'b0);
    check("no_commit_5", configout, 35'h2);
    idle_steps(D + 2);
    check("commit_7", configout, 35'h7);

    // Key load in IDLE, ignored in HOLD and alongside a write.
    step(1'b0, 35'h0, 1'b1, 2'b01, 1'b0);
    check("key_idle", 35'(syskey), 35'h1);
    step(1'b1, 35'h9, 1'b1, 2'b00, 1'b0);
    step(1'b0, 35'h0, 1'b1, 2'b11, 1'b0);
    check("key_hold", 35'(syskey), 35'h1);
    idle_steps(D + 2);

    // Asynchronous reset mid-HOLD drops the pending word immediately.
    step(1'b1, 35'h3, 1'b0, 2'b00, 1'b0);
    idle_steps(1);
    @(negedge clk);
    write_en = 1'b0; key_load = 1'b0; arst = 1'b1;
    #1;
    model_reset();
    check("async_cfg", configout, 35'h0);
    check("async_busy", 35'(busy), 35'h0);
    check("async_cnt", 35'(wr_count), 35'h0);
    step(1'b0, 35'h0, 1'b0, 2'b00, 1'b1);
    idle_steps(D + 2);

    // Counter saturation.
    for (int i = 0; i < 300; i++) step(1'b1, 35'(i), 1'b0, 2'b00, 1'b0);
    check("wr_sat", 35'(wr_count), 35'hFF);
    idle_steps(D + 2);
    check("last_word", configout, 35'(299));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        we;
      logic        kl;
      logic        rs;
      logic [34:0] d;
      we = ($urandom_range(0, 5) == 0);
      kl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 249) == 0);
      d  = 35'({$urandom(), $urandom()});
      step(we, d, kl, 2'($urandom()), rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
